pcie_perst_sequencer: RTL
=========================

// Module: pcie_perst_sequencer
// PURPOSE
//   Generates the fundamental-reset signal PERST_n for the PCIe link, the DUT and the reset-aware
//   PCIe monitor. It sits directly upstream of the monitor's PERST_n input.
//   Cold reset: waits for power-good to be stable, then holds PERST_n low before releasing it.
//   Warm reset: a request/ack handshake re-asserts PERST_n for a fixed hold time.
//   RESET_COUNT counts warm resets so the bench can correlate them with link retraining.
// PARAMETERS
//   PWR_STABLE_CYCLES  4    cycles power-good must stay stable before HOLD (>=1)
//   HOLD_CYCLES        100  cycles PERST_n stays low in HOLD and in WARM (>=1)
//   CNT_W              16   width of the internal timer; must hold max(PWR_STABLE_CYCLES,HOLD_CYCLES)-1
// PORTS
//   CLK          in   1  sequencer clock
//   RST          in   1  asynchronous, active-high reset
//   PWR_GOOD     in   1  asynchronous power-good; a 2-flop synchroniser drives pg_s
//   RST_REQ      in   1  warm-reset request, level sampled each CLK
//   RST_REQ_ACK  out  1  one-cycle pulse when a warm reset is accepted
//   PERST_n      out  1  fundamental reset to DUT/monitor, active-low, registered
//   STATE        out  3  current state encoding (debug/coverage)
//   RESET_COUNT  out  8  number of accepted warm resets, saturating
// BEHAVIOUR
//   RST asserted (any time, incl. mid-sequence): STATE=0 (OFF), PERST_n=0, RST_REQ_ACK=0,
//     RESET_COUNT=0, timer=0, synchroniser flops=0. Effect is immediate, with no clock needed.
//   All outputs are registered. PERST_n==1 exactly when STATE==ACTIVE.
//   States (encoding): OFF=0, PWR_STAB=1, HOLD=2, ACTIVE=3, WARM=4; codes 5-7 go to OFF.
//   OFF:      PERST_n=0. If pg_s==1 -> PWR_STAB, timer=0.
//   PWR_STAB: timer++. If pg_s==0 -> OFF.
//             Else if timer==PWR_STABLE_CYCLES-1 -> HOLD, timer=0.
//   HOLD:     timer++. If pg_s==0 -> OFF.
//             Else if timer==HOLD_CYCLES-1 -> ACTIVE (PERST_n=1 on the same edge).
//   ACTIVE:   If pg_s==0 -> OFF (PERST_n=0 on the next edge).
//             Else if RST_REQ==1 -> WARM, timer=0, RST_REQ_ACK=1 for one cycle,
//             RESET_COUNT+=1 (holds at 255).
//   WARM:     PERST_n=0, timer++. If pg_s==0 -> OFF.
//             Else if timer==HOLD_CYCLES-1 -> ACTIVE.
//   Priority: a pg_s drop beats RST_REQ in every state. RST_REQ outside ACTIVE is ignored:
//     no ack, no count.
//   A request held high continuously is re-accepted on the first ACTIVE cycle after each WARM
//     completes (one ack per acceptance).
//   Cold latency: PWR_GOOD sampled high at edge 1 -> pg_s=1 at edge 2 -> PWR_STAB at edge 3 ->
//     PERST_n=1 at edge PWR_STABLE_CYCLES+HOLD_CYCLES+3.
//   Warm latency: RST_REQ sampled at edge k -> PERST_n=0 and ACK=1 at edge k ->
//     PERST_n=1 at edge k+HOLD_CYCLES.
//   The timer never wraps: it is cleared on every state entry and compared for equality
//     before incrementing.
// TESTING (PWR_STABLE_CYCLES=4, HOLD_CYCLES=10 unless stated)
//   Cold boot: release RST, raise PWR_GOOD -> PERST_n rises exactly 17 edges later;
//     STATE passes 0,1,2,3.
//   PG glitch: PWR_GOOD low for 3 cycles during HOLD -> STATE=0 and PERST_n=0;
//     the full 17-edge sequence restarts on PWR_GOOD return.
//   Warm reset: 1-cycle RST_REQ in ACTIVE -> ACK pulses once, PERST_n low for exactly 10 cycles,
//     RESET_COUNT=1.
//   Ignored request: RST_REQ held in PWR_STAB/HOLD -> no ACK, RESET_COUNT unchanged;
//     ACK arrives on the first ACTIVE cycle.
//   Saturation: 300 warm resets (HOLD_CYCLES=1) -> RESET_COUNT=255, with no wrap to 0.
//   Async reset: assert RST between edges while ACTIVE -> PERST_n=0, STATE=0 and RESET_COUNT=0
//     before the next CLK edge.

Source files
------------

// File: rtl/pcie_perst_sequencer.sv
// PERST_n sequencer: cold power-up (power-good debounce, then hold) and warm-reset handshake.
// All outputs are registered; a warm-reset counter saturates at 255.
module pcie_perst_sequencer #(
    parameter int unsigned PWR_STABLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES       = 100,
    parameter int unsigned CNT_W             = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PWR_GOOD,
    input  logic       RST_REQ,
    output logic       RST_REQ_ACK,
    output logic       PERST_n,
    output logic [2:0] STATE,
    output logic [7:0] RESET_COUNT
);

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StPwrStab = 3'd1,
        StHold    = 3'd2,
        StActive  = 3'd3,
        StWarm    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] StabLast = CNT_W'(PWR_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             perst_n_q, perst_n_d;
    logic             ack_q, ack_d;
    logic [7:0]       count_q, count_d;
    logic             pg_meta_q, pg_s_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ack_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            StOff: begin
                if (pg_s_q) begin
                    state_d = StPwrStab;
                    timer_d = '0;
                end
            end
            StPwrStab: begin
                if (!pg_s_q) begin
                    state_d = StOff;
                    timer_d = '0;
                end else if (timer_q == StabLast) begin
                    state_d = StHold;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StHold, StWarm: begin
                if (!pg_s_q) begin
                    state_d = StOff;
                    timer_d = '0;
                end else if (timer_q == HoldLast) begin
                    state_d = StActive;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            StActive: begin
                // Loss of power-good wins over a concurrent warm-reset request.
                if (!pg_s_q) begin
                    state_d = StOff;
                    timer_d = '0;
                end else if (RST_REQ) begin
                    state_d = StWarm;
                    timer_d = '0;
                    ack_d   = 1'b1;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                end
            end
            default: begin
                state_d = StOff;
                timer_d = '0;
            end
        endcase
        perst_n_d = (state_d == StActive);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pg_meta_q <= 1'b0;
            pg_s_q    <= 1'b0;
            state_q   <= StOff;
            timer_q   <= '0;
            perst_n_q <= 1'b0;
            ack_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            pg_meta_q <= PWR_GOOD;
            pg_s_q    <= pg_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            perst_n_q <= perst_n_d;
            ack_q     <= ack_d;
            count_q   <= count_d;
        end
    end

    assign STATE       = state_q;
    assign PERST_n     = perst_n_q;
    assign RST_REQ_ACK = ack_q;
    assign RESET_COUNT = count_q;

endmodule
